// File: rtl/ld_str_mem_access_stage.sv
// ---------------------------------------------------------------------------
// ld_str_mem_access_stage
//
// Memory access stage of the load/store pipe. Accepts one resolved request
// per handshake, drives the data-memory request/acknowledge interface and
// returns load data to register write-back. LDM/STM requests are sequenced
// as one memory beat per listed register at ascending word addresses,
// lowest register first.
//
// Ports:
//   clk_in, reset_in            clock, asynchronous active-high reset
//   req_*                       request from the address generation stage;
//                               req_ready_out is high exactly in IDLE
//   rf_rd_addr_out/rf_rd_data_in  register-file read port used by STM beats
//   mem_*                       data-memory request/ack interface
//   wb_*                        one-cycle load write-back pulse
//   done_*                      one-cycle instruction completion pulse
// ---------------------------------------------------------------------------
module ld_str_mem_access_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic [TAG_W-1:0]  req_tag_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic              req_load_in,
    input  logic [3:0]        req_rd_addr_in,
    input  logic [DATA_W-1:0] req_str_data_in,
    input  logic              req_multiple_in,
    input  logic [15:0]       req_reg_list_in,
    input  logic              req_exec_in,
    output logic [3:0]        rf_rd_addr_out,
    input  logic [DATA_W-1:0] rf_rd_data_in,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    input  logic              mem_ack_in,
    input  logic [DATA_W-1:0] mem_rdata_in,
    output logic              wb_valid_out,
    output logic [3:0]        wb_rd_addr_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [TAG_W-1:0]  wb_tag_out,
    output logic              done_valid_out,
    output logic [TAG_W-1:0]  done_tag_out,
    output logic              done_exec_out
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 for an empty list (never used that way).
    function automatic logic [3:0] lowest_set_bit(input logic [15:0] list);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (list[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t            state_r, state_n_s;
    logic [TAG_W-1:0]  tag_r, tag_n_s;
    logic [ADDR_W-1:0] addr_r, addr_n_s;
    logic              load_r, load_n_s;
    logic [3:0]        rd_r, rd_n_s;
    logic [DATA_W-1:0] str_data_r, str_data_n_s;
    logic              multiple_r, multiple_n_s;
    logic [15:0]       list_r, list_n_s;
    logic [3:0]        cur_reg_r, cur_reg_n_s;
    logic              wb_valid_r, wb_valid_n_s;
    logic [3:0]        wb_rd_r, wb_rd_n_s;
    logic [DATA_W-1:0] wb_data_r, wb_data_n_s;
    logic [TAG_W-1:0]  wb_tag_r, wb_tag_n_s;
    logic              done_valid_r, done_valid_n_s;
    logic [TAG_W-1:0]  done_tag_r, done_tag_n_s;
    logic              done_exec_r, done_exec_n_s;
    logic [15:0]       remaining_s;
    logic              access_s;
    logic              stm_beat_s;

    // Next-state and next-register computation for the whole stage.
    always_comb begin
        state_n_s      = state_r;
        tag_n_s        = tag_r;
        addr_n_s       = addr_r;
        load_n_s       = load_r;
        rd_n_s         = rd_r;
        str_data_n_s   = str_data_r;
        multiple_n_s   = multiple_r;
        list_n_s       = list_r;
        cur_reg_n_s    = cur_reg_r;
        wb_valid_n_s   = 1'b0;
        wb_rd_n_s      = wb_rd_r;
        wb_data_n_s    = wb_data_r;
        wb_tag_n_s     = wb_tag_r;
        done_valid_n_s = 1'b0;
        done_tag_n_s   = done_tag_r;
        done_exec_n_s  = done_exec_r;
        // List with the beat currently on the bus removed.
        remaining_s    = list_r & ~(16'd1 << cur_reg_r);

        case (state_r)
            ST_IDLE: begin
                if (req_valid_in) begin
                    tag_n_s      = req_tag_in;
                    load_n_s     = req_load_in;
                    rd_n_s       = req_rd_addr_in;
                    str_data_n_s = req_str_data_in;
                    multiple_n_s = req_multiple_in;
                    list_n_s     = req_reg_list_in;
                    cur_reg_n_s  = lowest_set_bit(req_reg_list_in);
                    // Multiple transfers are always word aligned.
                    if (req_multiple_in) begin
                        addr_n_s = {req_addr_in[ADDR_W-1:2], 2'b00};
                    end else begin
                        addr_n_s = req_addr_in;
                    end
                    // Nothing to access: retire immediately without a memory cycle.
                    if (!req_exec_in || (req_multiple_in && (req_reg_list_in == 16'd0))) begin
                        done_valid_n_s = 1'b1;
                        done_tag_n_s   = req_tag_in;
                        done_exec_n_s  = 1'b0;
                        state_n_s      = ST_IDLE;
                    end else begin
                        state_n_s      = ST_ACCESS;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ack_in) begin
                    if (load_r) begin
                        wb_valid_n_s = 1'b1;
                        wb_rd_n_s    = multiple_r ? cur_reg_r : rd_r;
                        wb_data_n_s  = mem_rdata_in;
                        wb_tag_n_s   = tag_r;
                    end else begin
                        wb_valid_n_s = 1'b0;
                    end
                    if (multiple_r && (remaining_s != 16'd0)) begin
                        list_n_s    = remaining_s;
                        addr_n_s    = addr_r + ADDR_W'(32'd4);
                        cur_reg_n_s = lowest_set_bit(remaining_s);
                        state_n_s   = ST_ACCESS;
                    end else begin
                        state_n_s      = ST_IDLE;
                        done_valid_n_s = 1'b1;
                        done_tag_n_s   = tag_r;
                        done_exec_n_s  = 1'b1;
                    end
                end else begin
                    state_n_s = ST_ACCESS;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_r      <= ST_IDLE;
            tag_r        <= {TAG_W{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            load_r       <= 1'b0;
            rd_r         <= 4'd0;
            str_data_r   <= {DATA_W{1'b0}};
            multiple_r   <= 1'b0;
            list_r       <= 16'd0;
            cur_reg_r    <= 4'd0;
            wb_valid_r   <= 1'b0;
            wb_rd_r      <= 4'd0;
            wb_data_r    <= {DATA_W{1'b0}};
            wb_tag_r     <= {TAG_W{1'b0}};
            done_valid_r <= 1'b0;
            done_tag_r   <= {TAG_W{1'b0}};
            done_exec_r  <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            tag_r        <= tag_n_s;
            addr_r       <= addr_n_s;
            load_r       <= load_n_s;
            rd_r         <= rd_n_s;
            str_data_r   <= str_data_n_s;
            multiple_r   <= multiple_n_s;
            list_r       <= list_n_s;
            cur_reg_r    <= cur_reg_n_s;
            wb_valid_r   <= wb_valid_n_s;
            wb_rd_r      <= wb_rd_n_s;
            wb_data_r    <= wb_data_n_s;
            wb_tag_r     <= wb_tag_n_s;
            done_valid_r <= done_valid_n_s;
            done_tag_r   <= done_tag_n_s;
            done_exec_r  <= done_exec_n_s;
        end
    end

    // Memory-side outputs are decoded only from registered state, so they
    // hold steady until the ack and are all zero outside ACCESS.
    assign access_s       = (state_r == ST_ACCESS);
    assign stm_beat_s     = access_s & multiple_r & ~load_r;
    assign req_ready_out  = (state_r == ST_IDLE);
    assign mem_req_out    = access_s;
    assign mem_we_out     = access_s & ~load_r;
    assign mem_addr_out   = access_s ? addr_r : {ADDR_W{1'b0}};
    assign rf_rd_addr_out = stm_beat_s ? cur_reg_r : 4'd0;
    // STM data comes straight from the register-file read port.
    assign mem_wdata_out  = stm_beat_s ? rf_rd_data_in :
                            (mem_we_out ? str_data_r : {DATA_W{1'b0}});

    assign wb_valid_out   = wb_valid_r;
    assign wb_rd_addr_out = wb_rd_r;
    assign wb_data_out    = wb_data_r;
    assign wb_tag_out     = wb_tag_r;
    assign done_valid_out = done_valid_r;
    assign done_tag_out   = done_tag_r;
    assign done_exec_out  = done_exec_r;

endmodule

// File: tb/tb_ld_str_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_ld_str_mem_access_stage
//
// Directed self-checking bench for ld_str_mem_access_stage. Inputs change
// 1 ns after the rising edge; outputs are compared at the same point.
// The register file is modelled as Rn -> 0xA000000n.
// ---------------------------------------------------------------------------
module tb_ld_str_mem_access_stage;

    logic        clk_in;
    logic        reset_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [3:0]  req_tag_in;
    logic [31:0] req_addr_in;
    logic        req_load_in;
    logic [3:0]  req_rd_addr_in;
    logic [31:0] req_str_data_in;
    logic        req_multiple_in;
    logic [15:0] req_reg_list_in;
    logic        req_exec_in;
    logic [3:0]  rf_rd_addr_out;
    logic [31:0] rf_rd_data_in;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic        mem_ack_in;
    logic [31:0] mem_rdata_in;
    logic        wb_valid_out;
    logic [3:0]  wb_rd_addr_out;
    logic [31:0] wb_data_out;
    logic [3:0]  wb_tag_out;
    logic        done_valid_out;
    logic [3:0]  done_tag_out;
    logic        done_exec_out;

    int errors = 0;
    int checks = 0;
    int req_cycles = 0;
    int wb_count = 0;
    int done_count = 0;

    ld_str_mem_access_stage #(.ADDR_W(32), .DATA_W(32), .TAG_W(4)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_tag_in(req_tag_in), .req_addr_in(req_addr_in),
        .req_load_in(req_load_in), .req_rd_addr_in(req_rd_addr_in),
        .req_str_data_in(req_str_data_in), .req_multiple_in(req_multiple_in),
        .req_reg_list_in(req_reg_list_in), .req_exec_in(req_exec_in),
        .rf_rd_addr_out(rf_rd_addr_out), .rf_rd_data_in(rf_rd_data_in),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
        .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
        .mem_ack_in(mem_ack_in), .mem_rdata_in(mem_rdata_in),
        .wb_valid_out(wb_valid_out), .wb_rd_addr_out(wb_rd_addr_out),
        .wb_data_out(wb_data_out), .wb_tag_out(wb_tag_out),
        .done_valid_out(done_valid_out), .done_tag_out(done_tag_out),
        .done_exec_out(done_exec_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Register-file model: Rn reads as 0xA000000n.
    always_comb rf_rd_data_in = 32'hA000_0000 | {28'd0, rf_rd_addr_out};

    // Event counters sampled mid-cycle.
    always @(negedge clk_in) begin
        if (mem_req_out)    req_cycles++;
        if (wb_valid_out)   wb_count++;
        if (done_valid_out) done_count++;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_req(input logic [3:0] tag, input logic [31:0] addr,
                            input logic load, input logic [3:0] rd,
                            input logic [31:0] sdata, input logic mult,
                            input logic [15:0] list, input logic exec);
        req_tag_in = tag; req_addr_in = addr; req_load_in = load;
        req_rd_addr_in = rd; req_str_data_in = sdata; req_multiple_in = mult;
        req_reg_list_in = list; req_exec_in = exec; req_valid_in = 1'b1;
        tick();
        req_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        req_valid_in = 1'b0; req_tag_in = 4'd0; req_addr_in = 32'd0;
        req_load_in = 1'b0; req_rd_addr_in = 4'd0; req_str_data_in = 32'd0;
        req_multiple_in = 1'b0; req_reg_list_in = 16'd0; req_exec_in = 1'b0;
        mem_ack_in = 1'b0; mem_rdata_in = 32'd0;
        repeat (3) tick();
        checks++;
        if ({req_ready_out, mem_req_out, mem_we_out, wb_valid_out, done_valid_out, done_exec_out} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 100000", {req_ready_out, mem_req_out, mem_we_out, wb_valid_out, done_valid_out, done_exec_out});
        end
        checks++;
        if ({mem_addr_out, mem_wdata_out, wb_data_out} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h wbdata=%h want 0", mem_addr_out, mem_wdata_out, wb_data_out);
        end
        checks++;
        if ({rf_rd_addr_out, wb_rd_addr_out, wb_tag_out, done_tag_out} !== 16'd0) begin
            errors++;
            $display("FAIL reset_idx: rf=%h wbrd=%h wbtag=%h donetag=%h want 0", rf_rd_addr_out, wb_rd_addr_out, wb_tag_out, done_tag_out);
        end
        reset_in = 1'b0;
        tick();
    endtask

    task automatic test_single_load();
        send_req(4'd5, 32'h0000_0100, 1'b1, 4'd3, 32'd0, 1'b0, 16'd0, 1'b1);
        // Two wait cycles plus the first request cycle: request held stable.
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mem_req_out, mem_we_out, req_ready_out, mem_addr_out} !== {3'b100, 32'h0000_0100}) begin
                errors++;
                $display("FAIL ld_req[%0d]: req=%b we=%b rdy=%b addr=%h want 1 0 0 00000100", i, mem_req_out, mem_we_out, req_ready_out, mem_addr_out);
            end
            if (i == 2) begin
                mem_ack_in = 1'b1; mem_rdata_in = 32'hDEAD_BEEF;
            end
            tick();
        end
        mem_ack_in = 1'b0;
        checks++;
        if ({wb_valid_out, wb_rd_addr_out, wb_data_out, wb_tag_out} !== {1'b1, 4'd3, 32'hDEAD_BEEF, 4'd5}) begin
            errors++;
            $display("FAIL ld_wb: v=%b rd=%0d data=%h tag=%0d want 1 3 deadbeef 5", wb_valid_out, wb_rd_addr_out, wb_data_out, wb_tag_out);
        end
        checks++;
        if ({done_valid_out, done_exec_out, done_tag_out, req_ready_out, mem_req_out} !== {2'b11, 4'd5, 2'b10}) begin
            errors++;
            $display("FAIL ld_done: v=%b exec=%b tag=%0d rdy=%b req=%b want 1 1 5 1 0", done_valid_out, done_exec_out, done_tag_out, req_ready_out, mem_req_out);
        end
        tick();
        checks++;
        if ({wb_valid_out, done_valid_out} !== 2'b00) begin
            errors++;
            $display("FAIL ld_pulse: wb=%b done=%b want 0 0", wb_valid_out, done_valid_out);
        end
    endtask

    task automatic test_single_store();
        int wb0;
        wb0 = wb_count;
        send_req(4'd6, 32'h0000_0204, 1'b0, 4'd0, 32'h1234_5678, 1'b0, 16'd0, 1'b1);
        checks++;
        if ({mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out} !== {2'b11, 32'h0000_0204, 32'h1234_5678}) begin
            errors++;
            $display("FAIL st_req: req=%b we=%b addr=%h wdata=%h want 1 1 00000204 12345678", mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out);
        end
        mem_ack_in = 1'b1;
        tick();
        mem_ack_in = 1'b0;
        checks++;
        if ({done_valid_out, done_exec_out, done_tag_out, wb_valid_out, mem_req_out} !== {2'b11, 4'd6, 2'b00}) begin
            errors++;
            $display("FAIL st_done: v=%b exec=%b tag=%0d wb=%b req=%b want 1 1 6 0 0", done_valid_out, done_exec_out, done_tag_out, wb_valid_out, mem_req_out);
        end
        tick();
        checks++;
        if (wb_count !== wb0) begin
            errors++;
            $display("FAIL st_no_wb: wb pulses=%0d want %0d", wb_count, wb0);
        end
    endtask

    task automatic test_ldm();
        logic [3:0] exp_reg [4];
        int d0;
        exp_reg[0] = 4'd0; exp_reg[1] = 4'd2; exp_reg[2] = 4'd5; exp_reg[3] = 4'd15;
        d0 = done_count;
        send_req(4'd7, 32'h0000_1000, 1'b1, 4'd0, 32'd0, 1'b1, 16'h8025, 1'b1);
        mem_ack_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({mem_req_out, mem_we_out, done_valid_out, mem_addr_out} !== {3'b100, 32'h0000_1000 + 32'(4 * i)}) begin
                errors++;
                $display("FAIL ldm_beat[%0d]: req=%b we=%b done=%b addr=%h want 1 0 0 %h", i, mem_req_out, mem_we_out, done_valid_out, mem_addr_out, 32'h0000_1000 + 32'(4 * i));
            end
            if (i > 0) begin
                checks++;
                if ({wb_valid_out, wb_rd_addr_out, wb_data_out} !== {1'b1, exp_reg[i-1], 32'hCAFE_0000 | 32'(i - 1)}) begin
                    errors++;
                    $display("FAIL ldm_wb[%0d]: v=%b rd=%0d data=%h want 1 %0d %h", i - 1, wb_valid_out, wb_rd_addr_out, wb_data_out, exp_reg[i-1], 32'hCAFE_0000 | 32'(i - 1));
                end
            end
            mem_rdata_in = 32'hCAFE_0000 | 32'(i);
            tick();
        end
        mem_ack_in = 1'b0;
        checks++;
        if ({wb_valid_out, wb_rd_addr_out, wb_data_out, done_valid_out, done_exec_out, mem_req_out} !== {1'b1, 4'd15, 32'hCAFE_0003, 3'b110}) begin
            errors++;
            $display("FAIL ldm_last: wb=%b rd=%0d data=%h done=%b exec=%b req=%b want 1 15 cafe0003 1 1 0", wb_valid_out, wb_rd_addr_out, wb_data_out, done_valid_out, done_exec_out, mem_req_out);
        end
        tick();
        checks++;
        if (done_count !== d0 + 1) begin
            errors++;
            $display("FAIL ldm_done_count: got %0d want %0d", done_count - d0, 1);
        end
    endtask

    task automatic test_stm_wrap();
        send_req(4'd8, 32'hFFFF_FFFC, 1'b0, 4'd0, 32'd0, 1'b1, 16'h0006, 1'b1);
        checks++;
        if ({mem_we_out, rf_rd_addr_out, mem_addr_out, mem_wdata_out} !== {1'b1, 4'd1, 32'hFFFF_FFFC, 32'hA000_0001}) begin
            errors++;
            $display("FAIL stm_beat0: we=%b rf=%0d addr=%h wdata=%h want 1 1 fffffffc a0000001", mem_we_out, rf_rd_addr_out, mem_addr_out, mem_wdata_out);
        end
        mem_ack_in = 1'b1;
        tick();
        checks++;
        if ({mem_req_out, mem_we_out, rf_rd_addr_out, mem_addr_out, mem_wdata_out} !== {2'b11, 4'd2, 32'h0000_0000, 32'hA000_0002}) begin
            errors++;
            $display("FAIL stm_beat1: req=%b we=%b rf=%0d addr=%h wdata=%h want 1 1 2 00000000 a0000002", mem_req_out, mem_we_out, rf_rd_addr_out, mem_addr_out, mem_wdata_out);
        end
        tick();
        mem_ack_in = 1'b0;
        checks++;
        if ({done_valid_out, done_exec_out, wb_valid_out, rf_rd_addr_out, mem_req_out} !== {3'b110, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL stm_done: done=%b exec=%b wb=%b rf=%0d req=%b want 1 1 0 0 0", done_valid_out, done_exec_out, wb_valid_out, rf_rd_addr_out, mem_req_out);
        end
        tick();
    endtask

    task automatic test_no_access();
        int r0;
        r0 = req_cycles;
        send_req(4'd10, 32'h0000_0400, 1'b1, 4'd1, 32'd0, 1'b0, 16'd0, 1'b0);
        checks++;
        if ({done_valid_out, done_exec_out, done_tag_out, req_ready_out, mem_req_out} !== {2'b10, 4'd10, 2'b10}) begin
            errors++;
            $display("FAIL cond_fail: done=%b exec=%b tag=%0d rdy=%b req=%b want 1 0 10 1 0", done_valid_out, done_exec_out, done_tag_out, req_ready_out, mem_req_out);
        end
        send_req(4'd11, 32'h0000_0500, 1'b1, 4'd0, 32'd0, 1'b1, 16'd0, 1'b1);
        checks++;
        if ({done_valid_out, done_exec_out, done_tag_out, req_ready_out, mem_req_out} !== {2'b10, 4'd11, 2'b10}) begin
            errors++;
            $display("FAIL empty_list: done=%b exec=%b tag=%0d rdy=%b req=%b want 1 0 11 1 0", done_valid_out, done_exec_out, done_tag_out, req_ready_out, mem_req_out);
        end
        tick();
        checks++;
        if ({done_valid_out, 32'(req_cycles - r0)} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL no_access: done=%b req_cycles=%0d want 0 0", done_valid_out, req_cycles - r0);
        end
    endtask

    task automatic test_reset_mid();
        int wb0;
        int d0;
        send_req(4'd12, 32'h0000_2000, 1'b1, 4'd0, 32'd0, 1'b1, 16'h000F, 1'b1);
        mem_ack_in = 1'b1; mem_rdata_in = 32'h5555_0000;
        tick();
        mem_ack_in = 1'b0;
        checks++;
        if ({mem_req_out, mem_addr_out} !== {1'b1, 32'h0000_2004}) begin
            errors++;
            $display("FAIL rst_mid_beat1: req=%b addr=%h want 1 00002004", mem_req_out, mem_addr_out);
        end
        reset_in = 1'b1;
        #1;
        checks++;
        if ({mem_req_out, req_ready_out, wb_valid_out, done_valid_out, rf_rd_addr_out} !== {4'b0100, 4'd0}) begin
            errors++;
            $display("FAIL rst_mid_async: req=%b rdy=%b wb=%b done=%b rf=%0d want 0 1 0 0 0", mem_req_out, req_ready_out, wb_valid_out, done_valid_out, rf_rd_addr_out);
        end
        wb0 = wb_count; d0 = done_count;
        tick();
        reset_in = 1'b0;
        repeat (3) tick();
        checks++;
        if ({32'(wb_count - wb0), 32'(done_count - d0), mem_req_out, req_ready_out} !== {64'd0, 2'b01}) begin
            errors++;
            $display("FAIL rst_mid_quiet: wb=%0d done=%0d req=%b rdy=%b want 0 0 0 1", wb_count - wb0, done_count - d0, mem_req_out, req_ready_out);
        end
        send_req(4'd13, 32'h0000_0300, 1'b1, 4'd7, 32'd0, 1'b0, 16'd0, 1'b1);
        mem_ack_in = 1'b1; mem_rdata_in = 32'h0BAD_F00D;
        tick();
        mem_ack_in = 1'b0;
        checks++;
        if ({wb_valid_out, wb_rd_addr_out, wb_data_out, wb_tag_out, done_valid_out, done_exec_out} !== {1'b1, 4'd7, 32'h0BAD_F00D, 4'd13, 2'b11}) begin
            errors++;
            $display("FAIL rst_after: wb=%b rd=%0d data=%h tag=%0d done=%b exec=%b want 1 7 0badf00d 13 1 1", wb_valid_out, wb_rd_addr_out, wb_data_out, wb_tag_out, done_valid_out, done_exec_out);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_single_store();
        test_ldm();
        test_stm_wrap();
        test_no_access();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
